// File: rtl/mips32_mem_dump_if.sv
// Memory read port and (address, word) output stream of the dump engine.
interface mips32_mem_dump_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;

    logic              dout_valid;
    logic              dout_ready;
    logic [ADDR_W-1:0] dout_addr;
    logic [DATA_W-1:0] dout_data;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rd_data,
        output dout_valid, dout_addr, dout_data,
        input  dout_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rd_data,
        input  dout_valid, dout_addr, dout_data,
        output dout_ready
    );
endinterface

// File: rtl/mips32_mem_dump.sv
// Post-HALT memory readback: walks [base, base+count) through a 1-cycle sync read port, streams (addr, word), sums words.
// Latency: start->rd_en 2 cycles, rd_en->dout_valid 2 cycles; one word per 3 cycles; dout held stable while dout_ready=0.
module mips32_mem_dump #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              halted,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    mips32_mem_dump_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, WAIT_HALT, ISSUE, CAPTURE, HOLD, FIN
    } state_t;

    localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remaining;
    logic              hs;

    assign hs = bus.dout_valid && bus.dout_ready;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.mem_rd_en = 1'b0;
        bus.mem_addr  = '0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = WAIT_HALT;
            end
            WAIT_HALT: begin
                busy = 1'b1;
                if (halted) state_nxt = (remaining == '0) ? FIN : ISSUE;
            end
            ISSUE: begin
                busy          = 1'b1;
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = cur_addr;
                state_nxt     = CAPTURE;
            end
            CAPTURE: begin
                busy      = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                busy = 1'b1;
                // remaining is decremented on this same edge, so compare against one
                if (hs) state_nxt = (remaining == REM_ONE) ? FIN : ISSUE;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr       <= '0;
            remaining      <= '0;
            checksum       <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_addr  <= '0;
            bus.dout_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr  <= base_addr;
                        remaining <= count;
                        checksum  <= '0;
                    end
                end
                CAPTURE: begin
                    bus.dout_data  <= bus.mem_rd_data;
                    bus.dout_addr  <= cur_addr;
                    bus.dout_valid <= 1'b1;
                    checksum       <= checksum + bus.mem_rd_data;
                end
                HOLD: begin
                    if (hs) begin
                        bus.dout_valid <= 1'b0;
                        remaining      <= remaining - REM_ONE;
                        cur_addr       <= cur_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_mem_dump.sv
// Directed bench for mips32_mem_dump with a 1-cycle synchronous memory model.
module tb_mips32_mem_dump;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk1;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              halted;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    mips32_mem_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mips32_mem_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .halted    (halted),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .bus       (bus)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic [DATA_W-1:0] mem [1024];
    always @(posedge clk1) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc;
    int rd_cnt, vld_cnt, done_cnt, done_cyc, first_rd, first_vld;
    logic busy_at_done;
    logic [ADDR_W-1:0] beat_addr [$];
    logic [DATA_W-1:0] beat_data [$];

    always @(posedge clk1) cyc++;

    always @(negedge clk1) begin
        if (bus.mem_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (bus.dout_valid) begin
            vld_cnt++;
            if (first_vld < 0) first_vld = cyc;
        end
        if (bus.dout_valid && bus.dout_ready) begin
            beat_addr.push_back(bus.dout_addr);
            beat_data.push_back(bus.dout_data);
        end
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic clear_mon();
        rd_cnt = 0; vld_cnt = 0; done_cnt = 0; done_cyc = -1;
        first_rd = -1; first_vld = -1; busy_at_done = 1'bx;
        beat_addr.delete();
        beat_data.delete();
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
        start = 1'b1; base_addr = b; count = n; start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (done_cnt > 0) begin ok = 1'b1; break; end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        logic [127:0] outs;
        rst_n = 1'b0;
        tick(); tick();
        outs = {bus.mem_rd_en, bus.mem_addr, bus.dout_valid, bus.dout_addr, bus.dout_data, busy, done, checksum};
        checks++;
        if (outs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, done, bus.mem_rd_en, bus.dout_valid} !== 4'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b done=%b rd=%b vld=%b want all 0", busy, done, bus.mem_rd_en, bus.dout_valid);
        end
    endtask

    task automatic test_basic();
        bit ok;
        clear_mon();
        halted = 1'b1; bus.dout_ready = 1'b1;
        do_start(10'd198, 11'd3);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: done not seen, want done"); end
        checks++;
        if (beat_addr.size() != 3) begin
            errors++; $display("FAIL basic_beats: got %0d beats want 3", beat_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (beat_addr[i] !== 10'(198 + i) || beat_data[i] !== mem[198 + i]) begin
                    errors++; $display("FAIL basic_beat%0d: got (%0d,%0d) want (%0d,%0d)", i, beat_addr[i], beat_data[i], 198 + i, mem[198 + i]);
                end
            end
        end
        checks++; if (checksum !== 32'd35) begin errors++; $display("FAIL basic_checksum: got %0d want 35", checksum); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
        checks++; if (first_rd - start_cyc != 2) begin errors++; $display("FAIL basic_rd_latency: got %0d want 2", first_rd - start_cyc); end
        checks++; if (first_vld - first_rd != 2) begin errors++; $display("FAIL basic_vld_latency: got %0d want 2", first_vld - first_rd); end
        checks++; if (done_cyc - start_cyc != 11) begin errors++; $display("FAIL basic_total_latency: got %0d want 11", done_cyc - start_cyc); end
        checks++; if (rd_cnt != 3) begin errors++; $display("FAIL basic_reads: got %0d want 3", rd_cnt); end
    endtask

    task automatic test_wait_halt();
        bit ok;
        int h;
        clear_mon();
        halted = 1'b0; bus.dout_ready = 1'b1;
        do_start(10'd198, 11'd1);
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (rd_cnt != 0 || vld_cnt != 0) begin
            errors++; $display("FAIL halt_wait_quiet: reads=%0d valids=%0d want 0/0", rd_cnt, vld_cnt);
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL halt_wait_busy: got %b want 1", busy); end
        halted = 1'b1; h = cyc;
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL halt_done_timeout: done not seen, want done"); end
        checks++; if (first_rd - h != 1) begin errors++; $display("FAIL halt_rd_latency: got %0d want 1", first_rd - h); end
        checks++; if (checksum !== 32'd24) begin errors++; $display("FAIL halt_checksum: got %0d want 24", checksum); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int guard;
        clear_mon();
        halted = 1'b1; bus.dout_ready = 1'b1;
        do_start(10'd198, 11'd3);
        guard = 0;
        while (beat_addr.size() < 1 && guard < 100) begin tick(); guard++; end
        bus.dout_ready = 1'b0;
        while (!bus.dout_valid && guard < 100) begin tick(); guard++; end
        checks++; if (guard >= 100) begin errors++; $display("FAIL bp_timeout: second beat not valid, want valid"); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.dout_valid !== 1'b1 || bus.dout_addr !== 10'd199 || bus.dout_data !== 32'd7 ||
                checksum !== 32'd31 || rd_cnt != 2) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b addr=%0d data=%0d sum=%0d reads=%0d want 1/199/7/31/2",
                         i, bus.dout_valid, bus.dout_addr, bus.dout_data, checksum, rd_cnt);
            end
            tick();
        end
        bus.dout_ready = 1'b1;
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout: done not seen, want done"); end
        checks++;
        if (checksum !== 32'd35 || beat_addr.size() != 3 || rd_cnt != 3) begin
            errors++; $display("FAIL bp_final: sum=%0d beats=%0d reads=%0d want 35/3/3", checksum, beat_addr.size(), rd_cnt);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [ADDR_W-1:0] exp_addr [4];
        exp_addr[0] = 10'd1022; exp_addr[1] = 10'd1023; exp_addr[2] = 10'd0; exp_addr[3] = 10'd1;
        clear_mon();
        halted = 1'b1; bus.dout_ready = 1'b1;
        do_start(10'd1022, 11'd4);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_done_timeout: done not seen, want done"); end
        checks++;
        if (beat_addr.size() != 4) begin
            errors++; $display("FAIL wrap_beats: got %0d want 4", beat_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (beat_addr[i] !== exp_addr[i] || beat_data[i] !== 32'(i + 1)) begin
                    errors++; $display("FAIL wrap_beat%0d: got (%0d,%0d) want (%0d,%0d)", i, beat_addr[i], beat_data[i], exp_addr[i], i + 1);
                end
            end
        end
        checks++; if (checksum !== 32'd10) begin errors++; $display("FAIL wrap_checksum: got %0d want 10", checksum); end
    endtask

    task automatic test_count_zero();
        bit ok;
        clear_mon();
        halted = 1'b1;
        do_start(10'd5, 11'd0);
        wait_done(50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_done_timeout: done not seen, want done"); end
        checks++; if (done_cyc - start_cyc != 2) begin errors++; $display("FAIL zero_done_latency: got %0d want 2", done_cyc - start_cyc); end
        checks++;
        if (rd_cnt != 0 || vld_cnt != 0) begin
            errors++; $display("FAIL zero_activity: reads=%0d valids=%0d want 0/0", rd_cnt, vld_cnt);
        end
        checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL zero_checksum: got %0d want 0", checksum); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [127:0] outs;
        int guard;
        clear_mon();
        halted = 1'b1; bus.dout_ready = 1'b0;
        do_start(10'd198, 11'd3);
        guard = 0;
        while (!bus.dout_valid && guard < 50) begin tick(); guard++; end
        rst_n = 1'b0;
        #1;
        outs = {bus.mem_rd_en, bus.mem_addr, bus.dout_valid, bus.dout_addr, bus.dout_data, busy, done, checksum};
        checks++;
        if (guard >= 50 || outs !== '0) begin
            errors++; $display("FAIL midreset_outputs: got %h (guard %0d) want 0", outs, guard);
        end
        tick();
        rst_n = 1'b1;
        bus.dout_ready = 1'b1;
        tick();
        clear_mon();
        do_start(10'd200, 11'd1);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midreset_done_timeout: done not seen, want done"); end
        checks++;
        if (beat_addr.size() != 1 || beat_addr[0] !== 10'd200 || beat_data[0] !== 32'd4 || checksum !== 32'd4) begin
            errors++; $display("FAIL midreset_redump: beats=%0d sum=%0d want 1 beat (200,4) sum 4", beat_addr.size(), checksum);
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        clear_mon();
        halted = 1'b1; bus.dout_ready = 1'b1;
        do_start(10'd198, 11'd2);
        tick(); tick();
        start = 1'b1; base_addr = 10'd0; count = 11'd5;
        tick();
        start = 1'b0;
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_start_timeout: done not seen, want done"); end
        checks++;
        if (beat_addr.size() != 2 || checksum !== 32'd31 || rd_cnt != 2) begin
            errors++; $display("FAIL busy_start_ignored: beats=%0d sum=%0d reads=%0d want 2/31/2", beat_addr.size(), checksum, rd_cnt);
        end else begin
            checks++;
            if (beat_addr[0] !== 10'd198 || beat_addr[1] !== 10'd199) begin
                errors++; $display("FAIL busy_start_addrs: got %0d,%0d want 198,199", beat_addr[0], beat_addr[1]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hdead_0000 + 32'(i);
        mem[198] = 32'd24; mem[199] = 32'd7; mem[200] = 32'd4;
        mem[1022] = 32'd1; mem[1023] = 32'd2; mem[0] = 32'd3; mem[1] = 32'd4;
        start = 1'b0; base_addr = '0; count = '0; halted = 1'b0; bus.dout_ready = 1'b1;
        clear_mon();
        test_reset();
        test_basic();
        test_wait_halt();
        test_backpressure();
        test_wrap();
        test_count_zero();
        test_reset_mid();
        test_start_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips32_mem_dump.md
Name: mips32_mem_dump

Overview:
- Readback engine for the pipe_MIPS32 data/instruction memory. It is the reader counterpart to the program/data loader that fills memory before a run.
- After the processor asserts HALTED, it walks a programmed address range through a synchronous memory read port.
- It streams each (address, word) pair out on a valid/ready interface and accumulates a 32-bit wrap-around checksum.
- Sits between the memory array and the bench/debug UART, replacing hierarchical peeks such as Mem[198].

Parameters:
- ADDR_W, 10, memory word-address width (1024 words).
- DATA_W, 32, memory word width.

Ports:
- clk1  in  1  system clock; the block uses only the clk1 phase.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that requests a dump.
- base_addr  in  ADDR_W  first word address; sampled on an accepted start.
- count  in  ADDR_W+1  number of words to dump; sampled on an accepted start.
- halted  in  1  processor HALTED flag.
- mem_rd_en  out  1  read strobe to memory.
- mem_addr  out  ADDR_W  read address.
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- dout_valid  out  1  output word valid.
- dout_ready  in  1  downstream accept.
- dout_addr  out  ADDR_W  address of the current output word.
- dout_data  out  DATA_W  current output word.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse at dump completion.
- checksum  out  DATA_W  sum of all words dumped, modulo 2^DATA_W.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - mem_rd_en=0, mem_addr=0, dout_valid=0, dout_addr=0, dout_data=0, busy=0, done=0, checksum=0.
  - Reset mid-dump abandons the dump immediately; there is no partial-state retention.
- States: IDLE, WAIT_HALT, ISSUE, CAPTURE, HOLD, FIN.
- IDLE:
  - On start=1, latch base_addr into cur_addr and count into remaining, clear checksum, set busy=1, go to WAIT_HALT.
  - start while busy=1 is ignored.
- WAIT_HALT:
  - Stay while halted=0.
  - When halted=1: if remaining==0 go to FIN, else go to ISSUE.
- ISSUE:
  - Drive mem_rd_en=1 and mem_addr=cur_addr for exactly one cycle, then go to CAPTURE.
- CAPTURE:
  - Register dout_data=mem_rd_data and dout_addr=cur_addr.
  - checksum += mem_rd_data, truncated to DATA_W.
  - Set dout_valid=1 and go to HOLD.
- HOLD:
  - dout_valid, dout_data and dout_addr stay stable until dout_ready=1.
  - On the handshake cycle (valid&&ready): dout_valid←0, remaining−1, cur_addr+1.
  - cur_addr wraps modulo 2^ADDR_W, so 1023 is followed by 0.
  - Next state is ISSUE if the new remaining≠0, else FIN.
  - dout_ready is ignored while dout_valid=0.
- FIN:
  - done=1 for one cycle, busy←0, go to IDLE.
  - checksum holds its value until the next accepted start.
- Latency:
  - From start to the first mem_rd_en is 2 cycles when halted is already 1.
  - The first dout_valid follows 2 cycles after mem_rd_en.
  - With dout_ready tied 1, steady-state throughput is 1 word per 3 cycles.
- halted dropping during a dump is ignored; the halt is checked only in WAIT_HALT.
- count==0 still requires halted=1, then produces done with no memory reads and checksum=0.
- count > 2^ADDR_W is legal; addresses wrap and repeat.
- mem_rd_en is never asserted outside ISSUE. At most one read is outstanding at any time.

Test Plan:
- Preload Mem[198]=24, Mem[199]=7, Mem[200]=4; halted=1; start with base=198, count=3, dout_ready=1.
  -> Beats (198,24), (199,7), (200,4) in order; checksum=35; done pulses once; busy falls in the same cycle.
- Start with halted=0 and hold for 20 cycles, then assert halted.
  -> No mem_rd_en and no dout_valid before halted; the first mem_rd_en occurs 1 cycle after halted rises.
- Backpressure: dout_ready=0 for 5 cycles on the second beat.
  -> dout_data and dout_addr are stable all 5 cycles; no extra reads; checksum is unchanged until the next CAPTURE.
- Wrap: base=1022, count=4, Mem[1022..1023]=1,2, Mem[0..1]=3,4.
  -> Addresses 1022, 1023, 0, 1 in that order; checksum=10.
- count=0, halted=1.
  -> done pulses 2 cycles after start; zero mem_rd_en and zero dout_valid; checksum=0.
- Assert rst_n=0 mid-HOLD, then release and issue a new start with base=200, count=1.
  -> All outputs are 0 immediately at reset; the new dump returns (200,4) with checksum=4.
- Supplementary: a start pulse issued while busy has no effect on the dump in progress.
